// File: rtl/matrix_stream_tx.sv
// matrix_stream_tx: buffers MMIO element writes in a FIFO and streams them row-major
// with end-of-row and end-of-matrix flags.
module matrix_stream_tx #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int DIM_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DIM_WIDTH-1:0]          cfg_rows,
   input  logic [DIM_WIDTH-1:0]          cfg_cols,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          in_ready,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_matrix,
   output logic                          out_matrix_en,
   output logic                          out_matrix_end_row,
   output logic                          out_matrix_end,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          cfg_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic {IDLE, STREAM} state_t;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         cnt_q;
   logic [DIM_WIDTH-1:0]  rows_q, cols_q, row_q, col_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  en_q, end_row_q, end_q, ovf_q, err_q;
   logic                  push, pop, go, bad_cfg, last_col, last_row;
   assign in_ready = cnt_q < CW'(FIFO_DEPTH);
   assign pop      = state_q == STREAM && cnt_q != '0 && out_ready;
   // a pop frees a slot on the same edge, so a full FIFO still accepts a write then
   assign push     = in_valid && (in_ready || pop);
   assign go       = state_q == IDLE && start && cfg_rows != '0 && cfg_cols != '0;
   assign bad_cfg  = state_q == IDLE && start && (cfg_rows == '0 || cfg_cols == '0);
   assign last_col = col_q == cols_q - DIM_WIDTH'(1);
   assign last_row = row_q == rows_q - DIM_WIDTH'(1);
   assign out_matrix         = data_q;
   assign out_matrix_en      = en_q;
   assign out_matrix_end_row = end_row_q;
   assign out_matrix_end     = end_q;
   assign fifo_count         = cnt_q;
   assign overflow           = ovf_q;
   assign cfg_err            = err_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   always_comb
      state_d = state_q == IDLE ? (go ? STREAM : IDLE)
                                : (pop && last_col && last_row ? IDLE : STREAM);
   always_comb
      busy = state_q == STREAM;
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= in_data;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         rows_q    <= '0;
         cols_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         data_q    <= '0;
         en_q      <= 1'b0;
         end_row_q <= 1'b0;
         end_q     <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
         if (in_valid && !push) ovf_q <= 1'b1;
         if (bad_cfg) err_q <= 1'b1;
         if (go) begin
            rows_q <= cfg_rows;
            cols_q <= cfg_cols;
            row_q  <= '0;
            col_q  <= '0;
         end else if (pop) begin
            col_q <= last_col ? '0 : col_q + DIM_WIDTH'(1);
            if (last_col) row_q <= row_q + DIM_WIDTH'(1);
         end
         if (pop) data_q <= mem_q[rd_q];
         en_q      <= pop;
         end_row_q <= pop && last_col;
         end_q     <= pop && last_col && last_row;
      end
   end
endmodule
